// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised inputs, start/data/parity/stop deframing,
// parity/framing/timeout checks and a first-word-fall-through byte FIFO.
module ps2_rx_fifo #(
    parameter int DATA_W         = 8,
    parameter int PARITY_EN      = 1,
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    input  logic                            rd_en,
    input  logic                            err_clr,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            empty,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            bsy,
    output logic                            parity_err,
    output logic                            frame_err,
    output logic                            overflow,
    output logic                            timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   bit_in;

    state_t                 state;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_W-1:0]      shreg;
    logic                   par_bit;
    logic [TW-1:0]          to_cnt;

    logic [DATA_W-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;

    logic                   parity_ok;
    logic                   push;
    logic                   push_ok;
    logic                   pop;

    // Edge detect is registered so the fall pulse lands SYNC_STAGES+1 cycles after the pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
            fall      <= 1'b0;
            bit_in    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            fall      <= clk_prev & ~clk_sync[SYNC_STAGES-1];
            bit_in    <= data_sync[SYNC_STAGES-1];
        end
    end

    assign parity_ok = (PARITY_EN == 0) || (^{shreg, par_bit});
    assign push      = (state == STOP) && fall && bit_in && parity_ok;
    assign push_ok   = push && (!full || rd_en);
    assign pop       = rd_en && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            to_cnt      <= '0;
            bsy         <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Clear first so a same-cycle set below takes priority.
            if (err_clr) begin
                parity_err  <= 1'b0;
                frame_err   <= 1'b0;
                overflow    <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (state == IDLE) begin
                to_cnt <= '0;
                if (fall && !bit_in) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    bsy     <= 1'b1;
                end
            end else if (fall) begin
                to_cnt <= '0;
                if (state == DATA) begin
                    shreg <= {bit_in, shreg[DATA_W-1:1]};
                    if (bit_cnt == BW'(DATA_W - 1)) begin
                        state <= (PARITY_EN != 0) ? PAR : STOP;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end else if (state == PAR) begin
                    par_bit <= bit_in;
                    state   <= STOP;
                end else begin
                    state <= IDLE;
                    bsy   <= 1'b0;
                    if (!bit_in) begin
                        frame_err <= 1'b1;
                    end else if (!parity_ok) begin
                        parity_err <= 1'b1;
                    end else if (!push_ok) begin
                        overflow <= 1'b1;
                    end
                end
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state       <= IDLE;
                bsy         <= 1'b0;
                timeout_err <= 1'b1;
                to_cnt      <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // A push into a full FIFO with a simultaneous pop reuses the slot being vacated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: directed PS/2 frames, FIFO reads checked by a monitor.
module tb_ps2_rx_fifo;
    localparam int HALF = 10;
    localparam int TO   = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, bsy;
    logic [2:0] count;
    logic       parity_err, frame_err, overflow, timeout_err;

    logic [7:0] exp_q [$];
    int n_cmp = 0;
    int n_fail = 0;

    ps2_rx_fifo #(
        .DATA_W(8), .PARITY_EN(1), .FIFO_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rd_en(rd_en), .err_clr(err_clr), .rd_data(rd_data), .empty(empty),
        .full(full), .count(count), .bsy(bsy), .parity_err(parity_err),
        .frame_err(frame_err), .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted read must return the oldest expected byte.
    always @(negedge clk) begin
        if (rst && rd_en && !empty) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL read_unexpected got=%h required=none", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL read_data got=%h required=%h", rd_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic b, input bit rd_stop);
        @(posedge clk); #1 ps2_data = b;
        repeat (HALF - 1) @(posedge clk);
        #1 ps2_clk = 1'b0;
        if (rd_stop) begin
            // Fall pulse appears 3 cycles after the pin drops; evaluation on the 4th edge.
            repeat (3) @(posedge clk);
            #1 rd_en = 1'b1;
            @(posedge clk); #1 rd_en = 1'b0;
            repeat (HALF - 4) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                              input bit rd_stop);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 1'b0);
        drive_bit(~^d ^ bad_par, 1'b0);
        drive_bit(stop, rd_stop);
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        #1;
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i], 1'b0);
        @(posedge clk); #1 ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic read_one();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    task automatic check_flags(input string name, input int p, input int f, input int o,
                               input int t);
        check({name, "_parity_err"}, parity_err, p);
        check({name, "_frame_err"}, frame_err, f);
        check({name, "_overflow"}, overflow, o);
        check({name, "_timeout_err"}, timeout_err, t);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_bsy", bsy, 0);
        check("rst_rd_data", rd_data, 0);
        check_flags("rst", 0, 0, 0, 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);

        // Good 0x1C
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("good_count", count, 1);
        check("good_rd_data", rd_data, 8'h1C);
        check_flags("good", 0, 0, 0, 0);
        read_one();
        check("good_empty_after_read", empty, 1);

        // Bad parity
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        check("par_count", count, 0);
        check_flags("par", 1, 0, 0, 0);
        clear_errs();
        check("par_cleared", parity_err, 0);

        // Bad stop then good 0x12
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        check("stop_count", count, 0);
        check_flags("stop", 0, 1, 0, 0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        check("after_stop_rd_data", rd_data, 8'h12);
        check("after_stop_count", count, 1);
        read_one();
        clear_errs();

        // Overflow: five frames into four entries
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(i[7:0]);
            send_frame(i[7:0], 1'b0, 1'b1, 1'b0);
        end
        check("ovf_full", full, 1);
        check("ovf_count", count, 4);
        check_flags("ovf", 0, 0, 1, 0);
        repeat (4) read_one();
        check("ovf_empty_after_reads", empty, 1);
        clear_errs();
        check("ovf_cleared", overflow, 0);

        // Timeout after four data bits
        send_partial(8'hFF, 4);
        check("to_bsy_mid", bsy, 1);
        repeat (TO + 20) @(posedge clk);
        #1;
        check("to_bsy", bsy, 0);
        check("to_count", count, 0);
        check_flags("to", 0, 0, 0, 1);
        clear_errs();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("to_next_rd_data", rd_data, 8'h5A);
        check_flags("to_next", 0, 0, 0, 0);
        read_one();

        // Reset mid-frame
        send_partial(8'h00, 5);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check("rstmid_bsy", bsy, 0);
        exp_q.push_back(8'h29);
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        check("rstmid_count", count, 1);
        check("rstmid_rd_data", rd_data, 8'h29);
        check_flags("rstmid", 0, 0, 0, 0);
        read_one();

        // Full FIFO with a read on the stop-bit evaluation cycle
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h31 + i[7:0]);
            send_frame(8'h31 + i[7:0], 1'b0, 1'b1, 1'b0);
        end
        check("simul_full_before", full, 1);
        exp_q.push_back(8'h35);
        send_frame(8'h35, 1'b0, 1'b1, 1'b1);
        check("simul_count", count, 4);
        check("simul_full", full, 1);
        check_flags("simul", 0, 0, 0, 0);
        repeat (4) read_one();
        check("simul_empty", empty, 1);
        repeat (4) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver that runs entirely in the system clock domain. It synchronises the raw PS/2 clock and data lines, detects falling edges, and deframes start/data/parity/stop. It checks parity, framing and inter-edge timeout, and queues good bytes in a first-word-fall-through FIFO. It replaces directly-clocked shift receivers and sits between the keyboard pins and the scan-code decoder.

## Interface

- DATA_W, 8: data bits per frame, LSB first.
- PARITY_EN, 1: 1 = odd parity bit present and checked; 0 = no parity bit in the frame.
- FIFO_DEPTH, 4: entries; power of two, ≥2.
- SYNC_STAGES, 2: flip-flops per input synchroniser, ≥2.
- TIMEOUT_CYCLES, 5000: clk cycles allowed between consecutive PS/2 falling edges inside a frame.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- ps2_clk  in  1  raw PS/2 clock (asynchronous).
- ps2_data  in  1  raw PS/2 data (asynchronous).
- rd_en  in  1  pop head entry; ignored when empty.
- err_clr  in  1  clears all sticky error flags.
- rd_data  out  DATA_W  head entry; valid while !empty.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  $clog2(FIFO_DEPTH)+1  entries held.
- bsy  out  1  frame in progress.
- parity_err  out  1  sticky; a frame had bad parity.
- frame_err  out  1  sticky; bad stop bit.
- overflow  out  1  sticky; a good frame was dropped because the FIFO was full.
- timeout_err  out  1  sticky; a frame was aborted by timeout.

## Operation

- Both inputs pass through SYNC_STAGES flops, reset to 1. fall = sync_clk_prev & !sync_clk. Data is sampled from synchronised ps2_data on the fall cycle.
- FSM:
  - IDLE: on fall with data 0, go to DATA, clear the bit counter, bsy=1. On fall with data 1, stay in IDLE with no flags set; this is a glitch or false start.
  - DATA: on each fall, shift the bit in LSB first. After DATA_W bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: on fall, capture the bit and go to STOP.
  - STOP: on fall, evaluate, then go to IDLE and set bsy=0.
- Evaluation, in this precedence:
  1. Stop bit 0 → frame_err=1, no push.
  2. Parity check fails (PARITY_EN; XOR of data and parity bits must be 1) → parity_err=1, no push.
  3. Otherwise push. If the push is not accepted, set overflow=1.
- Push acceptance: accepted if !full, or if full and rd_en is high in the same cycle. A read and a push in the same cycle leave count unchanged.
- rd_en when empty is a no-op. count never wraps.
- Timeout counter:
  - Cleared on every fall and while in IDLE.
  - Increments otherwise.
  - On reaching TIMEOUT_CYCLES outside IDLE: return to IDLE, bsy=0, timeout_err=1, partial data discarded.
- err_clr clears all four sticky flags next cycle. A same-cycle set wins over clear.
- Reset values:
  - FSM IDLE, FIFO pointers 0, count=0, empty=1, full=0.
  - bsy=0, all error flags 0, rd_data=0.
  - Synchroniser flops at 1.
- Reset mid-frame drops the partial frame with no flag. The next frame must start with a start bit.

## Timing

- Raw ps2_clk fall to internal fall pulse: SYNC_STAGES+1 clk cycles.
- Stop-bit fall pulse → entry visible (empty=0, count incremented, rd_data valid) on the next clk edge.
- FWFT: rd_data always shows the head. rd_en on cycle N gives the next entry or empty=1 at N+1.
- bsy rises the cycle after the start-bit fall pulse. It falls the cycle after the stop-bit fall pulse or the timeout.
- Flags assert the cycle after the evaluating fall pulse.
- PS/2 clock period ≥ 4×(SYNC_STAGES+1) clk cycles is required for correct sampling.

## Test plan

- Defaults, frame 0x1C with parity 0 and stop 1 → count=1, rd_data=0x1C, no flags. rd_en → empty=1.
- 0x1C sent with parity 1 → parity_err=1, count stays 0. err_clr → parity_err=0.
- 0xF0 with good parity, stop 0 → frame_err=1 and no push. A following good 0x12 → rd_data=0x12.
- Five good frames 0x01..0x05 with no reads → full=1, count=4, overflow=1. Reads return 0x01..0x04 in order.
- Four data bits sent then ps2_clk held high for TIMEOUT_CYCLES → timeout_err=1, bsy=0. A following full 0x5A frame is received correctly.
- rst low after 5 data bits, then released, then a 0x29 frame → only 0x29 is queued and no flags are set. Separately, with the FIFO full and rd_en asserted on the stop-bit cycle → count stays 4, no overflow.
